velocity_cell_streamer: RTL and testbench

//  Sequencer between one velocity cell memory (single-port RAM, {vz,vy,vx} per word, addr 0 = particle count)
//  and the velocity cache / motion-update pipeline. On start: reads the count at addr 0, then reads addrs 1..N.

---
 rtl/velocity_cell_streamer.sv | 204 ++++++++++++++++++++
 tb/tb_velocity_cell_streamer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_cell_streamer.sv
// Purpose: reads the particle count at address 0 of a velocity cell RAM, then streams records 1..N out.
// Latency: first out_valid 2*RD_LAT+2 cycles after start; 1 record/cycle while out_ready stays high.
// Backpressure: RAM reads are credit-limited to the free space of a RD_LAT+1 deep output FIFO.
module velocity_cell_streamer #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_LAT       = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_count_err,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic                  o_mem_rden,
  output logic                  o_mem_wren,
  input  logic [DATA_WIDTH-1:0] i_mem_q,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [ADDR_WIDTH-1:0] o_out_pid,
  output logic                  o_out_last
);

  localparam int DEPTH = RD_LAT + 1;
  // Count width with headroom for fifo_count + outstanding.
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CNT, S_WAIT_CNT, S_STREAM, S_DRAIN, S_FINISH
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_count_err;
  logic [ADDR_WIDTH-1:0] r_n;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [1:0]            r_wait;

  // Read-return pipeline: one stage per cycle of RAM latency, record reads only.
  logic                  r_pv    [RD_LAT];
  logic [ADDR_WIDTH-1:0] r_ppid  [RD_LAT];
  logic                  r_plast [RD_LAT];

  // Output FIFO storage.
  logic [DATA_WIDTH-1:0] r_f_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_f_pid  [DEPTH];
  logic                  r_f_last [DEPTH];
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_fcnt;

  logic [CW-1:0]         w_outst;
  logic [CW-1:0]         w_used;
  logic                  w_fvld;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_rec_rd;
  logic                  w_cnt_rd;
  logic [ADDR_WIDTH-1:0] w_cnt_raw;

  // Number of record reads issued whose data has not yet been written into the FIFO.
  always_comb begin
    w_outst = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_outst = w_outst + {{(CW-1){1'b0}}, r_pv[i]};
    end
  end

  assign w_fvld    = (r_fcnt != '0);
  assign w_pop     = w_fvld & i_out_ready;
  assign w_push    = r_pv[RD_LAT-1];
  // The slot freed by this cycle's pop is counted as a credit, which keeps 1 record/cycle.
  assign w_used    = r_fcnt + w_outst - {{(CW-1){1'b0}}, w_pop};
  assign w_rec_rd  = (r_state == S_STREAM) && (w_used < CW'(DEPTH));
  assign w_cnt_rd  = (r_state == S_RD_CNT);
  assign w_cnt_raw = i_mem_q[ADDR_WIDTH-1:0];

  assign o_mem_rden    = w_rec_rd | w_cnt_rd;
  assign o_mem_address = w_cnt_rd ? '0 : (w_rec_rd ? r_rd_addr : r_mem_address);
  assign o_mem_wren    = 1'b0;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_count_err = r_count_err;
  assign o_out_valid = w_fvld;
  assign o_out_data  = r_f_data[r_rp];
  assign o_out_pid   = r_f_pid[r_rp];
  assign o_out_last  = r_f_last[r_rp];

  // Control FSM: count fetch, credit-limited streaming, drain, done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count_err <= 1'b0;
      r_n         <= '0;
      r_rd_addr   <= '0;
      r_wait      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_RD_CNT;
            r_busy      <= 1'b1;
            r_count_err <= 1'b0;
          end
        end
        S_RD_CNT: begin
          r_state <= S_WAIT_CNT;
          r_wait  <= '0;
        end
        S_WAIT_CNT: begin
          if (r_wait == 2'(RD_LAT - 1)) begin
            if (w_cnt_raw > MAX_N) begin
              r_n         <= MAX_N;
              r_count_err <= 1'b1;
            end else begin
              r_n <= w_cnt_raw;
            end
            if (w_cnt_raw == '0) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_STREAM;
              r_rd_addr <= ADDR_WIDTH'(1);
            end
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_STREAM: begin
          if (w_rec_rd) begin
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
            if (r_rd_addr == r_n) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!w_fvld && (w_outst == '0)) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Read-return tracking, output FIFO and held RAM address.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_address <= '0;
      r_wp          <= '0;
      r_rp          <= '0;
      r_fcnt        <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i]    <= 1'b0;
        r_ppid[i]  <= '0;
        r_plast[i] <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        r_f_data[i] <= '0;
        r_f_pid[i]  <= '0;
        r_f_last[i] <= 1'b0;
      end
    end else begin
      r_mem_address <= o_mem_address;
      r_pv[0]       <= w_rec_rd;
      r_ppid[0]     <= r_rd_addr;
      r_plast[0]    <= (r_rd_addr == r_n);
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_ppid[i]  <= r_ppid[i-1];
        r_plast[i] <= r_plast[i-1];
      end
      if (w_push) begin
        r_f_data[r_wp] <= i_mem_q;
        r_f_pid[r_wp]  <= r_ppid[RD_LAT-1];
        r_f_last[r_wp] <= r_plast[RD_LAT-1];
        r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
      end
      r_fcnt <= r_fcnt + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    end
  end

  // The credit rule must keep the FIFO from ever being pushed while full.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_push && !w_pop && (r_fcnt == CW'(DEPTH))));

endmodule

// File: tb/tb_velocity_cell_streamer.sv
// Purpose: directed bench for velocity_cell_streamer, instance 0 with RD_LAT=1 and instance 1 with RD_LAT=2.
// Latency: checks first-valid latency, back-to-back throughput, ordering, data, last, done and count_err.
// Backpressure: ready driven high, random or toggling; stalled outputs must hold.
module tb_velocity_cell_streamer;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, busy, done, cerr, rden, wren, valid, ready, last;
  logic [AW-1:0] addr [2];
  logic [AW-1:0] pid  [2];
  logic [DW-1:0] q    [2];
  logic [DW-1:0] data [2];

  velocity_cell_streamer #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .RD_LAT(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_count_err(cerr[0]), .o_mem_address(addr[0]), .o_mem_rden(rden[0]), .o_mem_wren(wren[0]),
    .i_mem_q(q[0]), .o_out_valid(valid[0]), .i_out_ready(ready[0]), .o_out_data(data[0]),
    .o_out_pid(pid[0]), .o_out_last(last[0]));

  velocity_cell_streamer #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .RD_LAT(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_count_err(cerr[1]), .o_mem_address(addr[1]), .o_mem_rden(rden[1]), .o_mem_wren(wren[1]),
    .i_mem_q(q[1]), .o_out_valid(valid[1]), .i_out_ready(ready[1]), .o_out_data(data[1]),
    .o_out_pid(pid[1]), .o_out_last(last[1]));

  // RAM model shared content, separate read pipelines per instance.
  logic [DW-1:0] mem [0:PN-1];
  logic [DW-1:0] q1 [2];
  logic [DW-1:0] q2;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) if (rden[k]) q1[k] <= mem[addr[k]];
    q2 <= q1[1];
  end
  assign q[0] = q1[0];
  assign q[1] = q2;

  function automatic logic [DW-1:0] rec(input int a);
    return {32'(a) ^ 32'hC0DE0000, 32'(a * 13 + 7), 32'hA5A50000 | 32'(a)};
  endfunction

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  int hs [2], exp_pid [2], exp_n [2], done_cnt [2], first_cyc [2], last_cyc [2], max_rd [2], s0 [2];
  int rmode [2];
  logic stall [2];
  logic [DW-1:0] s_data [2];
  logic [AW-1:0] s_pid [2];
  logic s_last [2];

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        stall[k] = 1'b0;
      end else begin
        if (stall[k]) begin
          chk("stall_valid", DW'(valid[k]), DW'(1));
          chk("stall_data", data[k], s_data[k]);
          chk("stall_pid", DW'(pid[k]), DW'(s_pid[k]));
          chk("stall_last", DW'(last[k]), DW'(s_last[k]));
        end
        if (valid[k] && first_cyc[k] < 0) first_cyc[k] = cyc;
        if (valid[k] && ready[k]) begin
          hs[k]++;
          chk("pid", DW'(pid[k]), DW'(exp_pid[k]));
          chk("data", data[k], rec(exp_pid[k]));
          chk("last", DW'(last[k]), DW'(exp_pid[k] == exp_n[k]));
          exp_pid[k]++;
          last_cyc[k] = cyc;
        end
        stall[k]  = valid[k] && !ready[k];
        s_data[k] = data[k];
        s_pid[k]  = pid[k];
        s_last[k] = last[k];
        if (rden[k] && int'(addr[k]) > max_rd[k]) max_rd[k] = int'(addr[k]);
        if (done[k]) begin
          done_cnt[k]++;
          chk("done_after_all", DW'(hs[k]), DW'(exp_n[k]));
        end
      end
    end
  end

  // Ready driver: 0 = always high, 1 = random, 2 = toggling.
  initial begin
    ready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (rmode[k])
          1:       ready[k] = 1'($urandom_range(0, 1));
          2:       ready[k] = ~ready[k];
          default: ready[k] = 1'b1;
        endcase
      end
    end
  end

  task automatic start_cell(input int k, input int cnt, input int mode);
    mem[0]       = DW'(cnt);
    exp_n[k]     = (cnt > PN - 1) ? PN - 1 : cnt;
    exp_pid[k]   = 1;
    hs[k]        = 0;
    done_cnt[k]  = 0;
    first_cyc[k] = -1;
    last_cyc[k]  = -1;
    max_rd[k]    = 0;
    rmode[k]     = mode;
    @(posedge clk);
    #1 start[k] = 1'b1;
    s0[k] = cyc + 1;
    @(posedge clk);
    #1 start[k] = 1'b0;
    chk("busy_after_start", DW'(busy[k]), DW'(1));
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (done_cnt[k] == 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", DW'(done_cnt[k] != 0), DW'(1));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input int k, input int err);
    chk("handshakes", DW'(hs[k]), DW'(exp_n[k]));
    chk("done_once", DW'(done_cnt[k]), DW'(1));
    chk("max_read_addr", DW'(max_rd[k]), DW'(exp_n[k]));
    chk("busy_idle", DW'(busy[k]), DW'(0));
    chk("count_err", DW'(cerr[k]), DW'(err));
    if (exp_n[k] > 0) chk("first_latency", DW'(first_cyc[k] - s0[k]), DW'(2 * (k + 1) + 2));
    else chk("no_valid", DW'(first_cyc[k] < 0), DW'(1));
  endtask

  task automatic reset_vals(input int k);
    chk("rst_busy", DW'(busy[k]), DW'(0));
    chk("rst_done", DW'(done[k]), DW'(0));
    chk("rst_cerr", DW'(cerr[k]), DW'(0));
    chk("rst_rden", DW'(rden[k]), DW'(0));
    chk("rst_wren", DW'(wren[k]), DW'(0));
    chk("rst_addr", DW'(addr[k]), DW'(0));
    chk("rst_valid", DW'(valid[k]), DW'(0));
    chk("rst_last", DW'(last[k]), DW'(0));
    chk("rst_data", data[k], DW'(0));
    chk("rst_pid", DW'(pid[k]), DW'(0));
  endtask

  initial begin
    int n;
    rst = 2'b11;
    start = 2'b00;
    for (int k = 0; k < 2; k++) begin
      rmode[k] = 0; hs[k] = 0; exp_pid[k] = 1; exp_n[k] = 0; done_cnt[k] = 0;
      first_cyc[k] = -1; last_cyc[k] = -1; max_rd[k] = 0; s0[k] = 0; stall[k] = 1'b0;
    end
    for (int a = 1; a < PN; a++) mem[a] = rec(a);
    mem[0] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_vals(0);
    reset_vals(1);
    rst = 2'b00;

    // T1: count=5, ready high, both latencies; back-to-back output.
    start_cell(0, 5, 0);
    wait_done(0);
    end_checks(0, 0);
    chk("t1_back_to_back", DW'(last_cyc[0] - first_cyc[0]), DW'(4));
    start_cell(1, 5, 0);
    wait_done(1);
    end_checks(1, 0);
    chk("t1_back_to_back_lat2", DW'(last_cyc[1] - first_cyc[1]), DW'(4));

    // T2: count=0.
    start_cell(0, 0, 0);
    wait_done(0);
    end_checks(0, 0);

    // T3: full cell with random backpressure.
    start_cell(0, 219, 1);
    wait_done(0);
    end_checks(0, 0);

    // T4: oversized count clips and flags; next start clears the flag.
    start_cell(0, 250, 0);
    wait_done(0);
    end_checks(0, 1);
    start_cell(0, 3, 0);
    chk("t4_err_cleared", DW'(cerr[0]), DW'(0));
    wait_done(0);
    end_checks(0, 0);

    // T5: reset mid-stream, then a clean restart.
    start_cell(0, 10, 0);
    n = 0;
    while (hs[0] < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_3", DW'(hs[0] >= 3), DW'(1));
    @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1;
    reset_vals(0);
    rst[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_done", DW'(done_cnt[0]), DW'(0));
    chk("t5_partial", DW'(hs[0] < 10), DW'(1));
    chk("t5_idle_valid", DW'(valid[0]), DW'(0));
    start_cell(0, 10, 1);
    wait_done(0);
    end_checks(0, 0);

    // T6: RD_LAT=2, toggling ready, extra start pulses while busy.
    start_cell(1, 8, 2);
    repeat (3) @(posedge clk);
    #1 start[1] = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 start[1] = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    wait_done(1);
    end_checks(1, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_restart_busy", DW'(busy[1]), DW'(0));
    chk("t6_no_restart_done", DW'(done_cnt[1]), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
